// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and datapath widths.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM backing the responder; contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

    // Read every cycle; the responder keeps idx steady while a response is held.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the MA-stage load/store port: one outstanding request, fixed access
// latency, then a held response carrying load data or a store ack plus an error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    if (LATENCY < 0 || LATENCY > 15) begin : g_badLatency
        $error("dmem_responder: LATENCY %0d is outside 0..15", LATENCY);
    end

    localparam logic [LAT_W-1:0] CNT_LOAD = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

    state_e                state_q, state_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic                  latWe_q, latWe_d;
    logic                  latErr_q, latErr_d;
    logic [DEPTH_LOG2-1:0] latIdx_q, latIdx_d;
    logic [WORD_W-1:0]     latWdata_q, latWdata_d;

    logic [DEPTH_LOG2-1:0] reqIdx;
    logic                  reqErr;
    logic                  accept;
    logic                  enterResp;
    logic                  ramWe;
    logic [WORD_W-1:0]     ramRdata;

    assign reqIdx = req_addr[DEPTH_LOG2+1:2];
    assign reqErr = (req_addr[1:0] != 2'b00) || (req_addr[WORD_W-1:DEPTH_LOG2+2] != '0);

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latWe_d    = latWe_q;
        latErr_d   = latErr_q;
        latIdx_d   = latIdx_q;
        latWdata_d = latWdata_q;
        enterResp  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    latWe_d    = req_we;
                    latErr_d   = reqErr;
                    latIdx_d   = reqIdx;
                    latWdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        state_d   = RESP;
                        enterResp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    enterResp = 1'b1;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        latWe_q    <= latWe_d;
        latErr_q   <= latErr_d;
        latIdx_q   <= latIdx_d;
        latWdata_q <= latWdata_d;
    end

    // Driving the RAM from the next-state latches lets a zero-latency request commit on its accept edge.
    assign ramWe = enterResp && !reset && latWe_d && !latErr_d;

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (ramWe),
        .idx  (latIdx_d),
        .wdata(latWdata_d),
        .rdata(ramRdata)
    );

    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && latErr_q;
    assign rsp_rdata = (rsp_valid && !latWe_q && !latErr_q) ? ramRdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder: two instances (latency 2 and 0)
// checked against a word-array model of storage, error decode and response timing.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqWe;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        rspReady;

    logic        reqValid2, reqReady2, rspValid2, rspErr2;
    logic [31:0] rspRdata2;
    logic        reqValid0, reqReady0, rspValid0, rspErr0;
    logic [31:0] rspRdata0;

    bit          sel0;
    int          vectors     = 0;
    int          miscompares = 0;

    logic [31:0] mem2 [int];
    logic [31:0] mem0 [int];
    int          written2 [$];
    int          written0 [$];

    logic        curReqReady, curRspValid, curRspErr;
    logic [31:0] curRspRdata;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid2), .req_ready(reqReady2), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspValid2), .rsp_ready(rspReady),
        .rsp_rdata(rspRdata2), .rsp_err(rspErr2)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid0), .req_ready(reqReady0), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspValid0), .rsp_ready(rspReady),
        .rsp_rdata(rspRdata0), .rsp_err(rspErr0)
    );

    assign curReqReady = sel0 ? reqReady0 : reqReady2;
    assign curRspValid = sel0 ? rspValid0 : rspValid2;
    assign curRspErr   = sel0 ? rspErr0   : rspErr2;
    assign curRspRdata = sel0 ? rspRdata0 : rspRdata2;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic setValid(input logic v);
        if (sel0) reqValid0 = v;
        else      reqValid2 = v;
    endtask

    // One full transaction starting just after a negedge with the selected instance idle.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int stall, input logic early);
        int          lat;
        int          idx;
        logic        expErr;
        logic [31:0] expData;
        lat     = sel0 ? 0 : 2;
        idx     = int'(addr >> 2);
        expErr  = (addr % 4 != 0) || (addr >= 32'h0000_1000);
        expData = 32'h0;
        if (!we && !expErr) expData = sel0 ? mem0[idx] : mem2[idx];
        if (we && !expErr) begin
            if (sel0) begin mem0[idx] = wdata; written0.push_back(idx); end
            else      begin mem2[idx] = wdata; written2.push_back(idx); end
        end

        checkOutput("reqReadyIdle", curReqReady, 1);
        reqWe    = we;
        reqAddr  = addr;
        reqWdata = wdata;
        rspReady = early && (stall == 0);
        setValid(1'b1);
        @(negedge clk);
        setValid(1'b0);
        for (int k = 0; k < lat; k++) begin
            checkOutput("rspValidEarly", curRspValid, 0);
            checkOutput("reqReadyBusy", curReqReady, 0);
            @(negedge clk);
        end
        checkOutput("rspValid", curRspValid, 1);
        checkOutput("rspRdata", curRspRdata, expData);
        checkOutput("rspErr", curRspErr, expErr);
        for (int s = 0; s < stall; s++) begin
            setValid(1'b1);
            @(negedge clk);
            checkOutput("stallValid", curRspValid, 1);
            checkOutput("stallRdata", curRspRdata, expData);
            checkOutput("stallErr", curRspErr, expErr);
            checkOutput("stallReqReady", curReqReady, 0);
        end
        setValid(1'b0);
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        checkOutput("rspValidDone", curRspValid, 0);
        checkOutput("reqReadyDone", curReqReady, 1);
    endtask

    initial begin
        logic        we;
        logic        early;
        logic [31:0] addr;
        int          pick;
        int          nWritten;
        int          stall;

        sel0      = 1'b0;
        reset     = 1'b1;
        reqValid2 = 1'b0;
        reqValid0 = 1'b0;
        reqWe     = 1'b0;
        reqAddr   = 32'h0;
        reqWdata  = 32'h0;
        rspReady  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetReqReady", reqReady2, 0);
        checkOutput("resetRspValid", rspValid2, 0);
        checkOutput("resetRspErr", rspErr2, 0);
        checkOutput("resetRspRdata", rspRdata2, 32'h0);
        checkOutput("resetRspValid0", rspValid0, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("postResetReady", reqReady2, 1);

        $display("[TB] directed sequence, latency 2");
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b1);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0011, 32'h1234_5678, 0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 0, 1'b1);
        applyStimulus(1'b0, 32'h0000_1000, 32'h0, 0, 1'b0);
        applyStimulus(1'b1, 32'h0000_1010, 32'h5555_5555, 0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 5, 1'b0);

        // Reset while the store is still waiting must drop it without a response.
        applyStimulus(1'b1, 32'h0000_0020, 32'h0000_0000, 0, 1'b0);
        reqWe    = 1'b1;
        reqAddr  = 32'h0000_0020;
        reqWdata = 32'hCAFE_F00D;
        reqValid2 = 1'b1;
        @(negedge clk);
        reqValid2 = 1'b0;
        checkOutput("waitRspValid", rspValid2, 0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("waitResetReady", reqReady2, 0);
        checkOutput("waitResetValid", rspValid2, 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("abortNoRsp", rspValid2, 0);
            checkOutput("abortReady", reqReady2, 1);
        end
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 0, 1'b0);

        // Reset while a response is held must drop rsp_valid.
        reqWe     = 1'b0;
        reqAddr   = 32'h0000_0010;
        reqValid2 = 1'b1;
        @(negedge clk);
        reqValid2 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("respHeld", rspValid2, 1);
        checkOutput("respHeldData", rspRdata2, 32'hDEAD_BEEF);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("respResetValid", rspValid2, 0);
        checkOutput("respResetData", rspRdata2, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed sequence, latency 0");
        sel0 = 1'b1;
        applyStimulus(1'b1, 32'h0000_0010, 32'hAABB_CCDD, 0, 1'b1);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 3, 1'b0);
        applyStimulus(1'b1, 32'h0000_0013, 32'h0F0F_0F0F, 0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 0, 1'b1);

        $display("[TB] randomized traffic");
        for (int d = 0; d < 2; d++) begin
            sel0 = (d == 1);
            for (int n = 0; n < 25; n++) begin
                nWritten = sel0 ? written0.size() : written2.size();
                we = 1'($urandom_range(0, 1));
                if (!we && nWritten == 0) we = 1'b1;
                pick = int'($urandom_range(0, 9));
                if (pick < 2) begin
                    addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
                end else if (pick < 3) begin
                    addr = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
                end else if (we) begin
                    addr = 32'($urandom_range(0, 63)) << 2;
                end else if (sel0) begin
                    addr = 32'(written0[$urandom_range(0, nWritten - 1)]) << 2;
                end else begin
                    addr = 32'(written2[$urandom_range(0, nWritten - 1)]) << 2;
                end
                stall = int'($urandom_range(0, 2));
                early = 1'($urandom_range(0, 1));
                applyStimulus(we, addr, $urandom, stall, early);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
